pwm_run_controller: RTL

PWM_RUN_CONTROLLER -- requirements
Module: pwm_run_controller

---
 rtl/pwm_run_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pwm_run_controller.sv
// Run/stop supervisor for a group of PWM chains: free-running timebase prescaler,
// start/stop sequencing with sync pulses, stop timeout and fault handling.
module pwm_run_controller #(
   parameter int N_CHAINS        = 2,
   parameter int PRESCALER_WIDTH = 16,
   parameter int SYNC_WIDTH      = 16,
   parameter int TIMEOUT_WIDTH   = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       fault,
   input  logic                       fault_clear,
   input  logic [PRESCALER_WIDTH-1:0] prescale,
   input  logic [SYNC_WIDTH-1:0]      sync_period,
   input  logic [TIMEOUT_WIDTH-1:0]   stop_timeout,
   input  logic [N_CHAINS-1:0]        chain_status,
   output logic                       timebase,
   output logic                       counter_run,
   output logic                       stop_request,
   output logic                       sync,
   output logic [2:0]                 state,
   output logic                       timeout_flag
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARMING   = 3'd1,
      RUNNING  = 3'd2,
      STOPPING = 3'd3,
      FAULT    = 3'd4
   } state_t;

   state_t                     state_q, state_d;
   logic [PRESCALER_WIDTH-1:0] presc_cnt;
   logic [SYNC_WIDTH-1:0]      sync_cnt, sync_cnt_d, sync_last;
   logic [TIMEOUT_WIDTH-1:0]   to_cnt, to_cnt_d;
   logic                       to_en, to_en_d;
   logic                       sync_d, timeout_flag_d;
   logic                       chains_idle;

   assign chains_idle = (chain_status == '0);
   assign sync_last   = sync_period - SYNC_WIDTH'(1);
   assign state       = state_q;

   // An over-range count (after prescale shrinks) wraps without producing a tick.
   always_ff @(posedge clock) begin
      if (reset) begin
         presc_cnt <= '0;
         timebase  <= 1'b0;
      end else if (presc_cnt >= prescale) begin
         presc_cnt <= '0;
         timebase  <= (presc_cnt == prescale);
      end else begin
         presc_cnt <= presc_cnt + PRESCALER_WIDTH'(1);
         timebase  <= 1'b0;
      end
   end

   always_comb begin
      state_d        = state_q;
      sync_cnt_d     = sync_cnt;
      to_cnt_d       = to_cnt;
      to_en_d        = to_en;
      sync_d         = 1'b0;
      timeout_flag_d = timeout_flag;
      if (fault) begin
         state_d = FAULT;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && !stop) state_d = ARMING;
            end
            ARMING: begin
               if (stop) begin
                  state_d = IDLE;
               end else if (timebase) begin
                  state_d    = RUNNING;
                  sync_d     = 1'b1;
                  sync_cnt_d = '0;
               end
            end
            RUNNING: begin
               if (stop) begin
                  state_d  = STOPPING;
                  to_cnt_d = stop_timeout;
                  to_en_d  = (stop_timeout != '0);
               end else if (timebase) begin
                  if ((sync_period != '0) && (sync_cnt >= sync_last)) begin
                     sync_d     = 1'b1;
                     sync_cnt_d = '0;
                  end else begin
                     sync_cnt_d = sync_cnt + SYNC_WIDTH'(1);
                  end
               end
            end
            STOPPING: begin
               // A zero timeout was latched as "wait forever".
               if (chains_idle) begin
                  state_d = IDLE;
               end else if (to_en) begin
                  if (to_cnt <= TIMEOUT_WIDTH'(1)) begin
                     state_d        = FAULT;
                     to_cnt_d       = '0;
                     timeout_flag_d = 1'b1;
                  end else begin
                     to_cnt_d = to_cnt - TIMEOUT_WIDTH'(1);
                  end
               end
            end
            FAULT: begin
               if (fault_clear && chains_idle) begin
                  state_d        = IDLE;
                  timeout_flag_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         sync_cnt     <= '0;
         to_cnt       <= '0;
         to_en        <= 1'b0;
         counter_run  <= 1'b0;
         stop_request <= 1'b0;
         sync         <= 1'b0;
         timeout_flag <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_cnt     <= sync_cnt_d;
         to_cnt       <= to_cnt_d;
         to_en        <= to_en_d;
         counter_run  <= (state_d == RUNNING);
         stop_request <= (state_d == STOPPING) || (state_d == FAULT);
         sync         <= sync_d;
         timeout_flag <= timeout_flag_d;
      end
   end

endmodule
